instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage feeding opcode_decoder: holds PC, reads 16-bit instructions from imem, registers IR.
//  Presents IR, opcode[4:0], PC and PC+2 downstream with a valid/ready handshake.
//  Applies PC redirects (br / rind targets chosen by PCSrc) and squashes any in-flight fetch.
// PARAMETERS
//  PC_W      16      PC / imem address width, byte address, instructions 2-byte aligned
//  INSTR_W   16      instruction width
//  RESET_PC  16'h0   PC loaded by reset
// PORTS
//  clk              in   1        single clock, all state on rising edge
//  reset            in   1        synchronous, active-high
//  o_imem_addr      out  PC_W     imem read address (= pc)
//  o_imem_rd        out  1        imem read request
//  i_imem_waitreq   in   1        imem stall; request held while high
//  i_imem_rddata    in   INSTR_W  read data, valid exactly 1 cycle after accepted request
//  o_valid          out  1        IR holds an instruction for decode
//  i_ready          in   1        decode accepts IR this cycle
//  o_instr          out  INSTR_W  instruction register
//  o_opcode         out  5        o_instr[4:0], to opcode_decoder
//  o_pc             out  PC_W     address o_instr was fetched from
//  o_pc_plus2       out  PC_W     o_pc + 2, mod 2^PC_W (WBSrc=010 source)
//  i_redirect       in   1        one-cycle redirect strobe (taken br/jump/call)
//  i_redirect_pc    in   PC_W     target; bit0 ignored (forced 0)
//  o_fetch_cnt      out  32       instructions delivered (valid&&ready), saturates at 32'hFFFFFFFF
// BEHAVIOUR
//  Reset (clk edge, reset=1): pc=RESET_PC, state=FETCH, o_valid=0, o_instr=0, o_pc=0, o_fetch_cnt=0;
//   o_imem_rd=0 while reset high. Reset mid-operation drops any outstanding read and valid IR.
//  States: FETCH, RESP, HOLD.
//   FETCH: o_imem_rd=1, o_imem_addr=pc. waitreq=1 -> stay, addr/rd stable. waitreq=0 -> RESP.
//   RESP : capture i_imem_rddata into o_instr, o_pc<=pc, pc<=pc+2, o_valid<=1 -> HOLD.
//   HOLD : o_valid=1, o_instr/o_pc stable. i_ready=1 -> o_valid<=0, cnt++, -> FETCH.
//          i_ready=0 -> stay (no further fetch issued).
//  Latency: request accepted cycle N -> o_valid high from N+2. With waitreq=0, i_ready=1:
//   one instruction per 3 cycles (FETCH, RESP, HOLD).
//  Redirect (highest priority, any state except during reset):
//   pc<=i_redirect_pc&~1, o_valid<=0, state<=FETCH next cycle.
//   In RESP: returned data discarded, pc not incremented, o_instr unchanged.
//   In FETCH with waitreq=1: request abandoned; new address presented next cycle.
//   In HOLD with i_ready=1 same cycle: instr counts as delivered (cnt++), then redirect applies.
//   In HOLD with i_ready=0: held instr squashed, not counted.
//  PC arithmetic mod 2^PC_W: 16'hFFFE + 2 -> 16'h0000, no flag. o_pc_plus2 from same rule.
//  o_opcode purely combinational slice of o_instr; all other outputs registered or state-decoded.
//  o_valid never falls without i_ready or redirect/reset; o_instr never changes while o_valid=1.
// TESTING
//  T1 reset: RESET_PC=0, release reset -> next cycle o_imem_rd=1, addr=0; o_valid=0, cnt=0.
//  T2 stream: imem[0]=16'h0021, [2]=16'h0041, ready=1, waitreq=0 -> o_instr 0021 @pc 0, then 0041 @pc 2,
//     o_opcode=5'b00001, o_pc_plus2=2/4, valid every 3rd cycle, cnt=2.
//  T3 waitreq high 3 cycles in FETCH -> addr/rd held 4 cycles, valid 2 cycles after waitreq drops.
//  T4 backpressure: ready=0 for 5 cycles in HOLD -> o_instr/o_pc constant, no imem_rd, cnt unchanged.
//  T5 redirect 16'h0101 in RESP -> data discarded, next addr 16'h0100, first valid has o_pc=0100;
//     redirect with valid&&ready same cycle -> cnt+1 and next addr = target.
//  T6 wrap: RESET_PC=16'hFFFE -> o_pc=FFFE, o_pc_plus2=0000, next fetch addr 0000;
//     assert reset during RESP -> o_valid=0, next addr RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem read port, decode handshake and redirect bundle for the fetch stage.
interface instr_fetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    o_imem_addr;
  logic               o_imem_rd;
  logic               i_imem_waitreq;
  logic [INSTR_W-1:0] i_imem_rddata;
  logic               o_valid;
  logic               i_ready;
  logic [INSTR_W-1:0] o_instr;
  logic [4:0]         o_opcode;
  logic [PC_W-1:0]    o_pc;
  logic [PC_W-1:0]    o_pc_plus2;
  logic               i_redirect;
  logic [PC_W-1:0]    i_redirect_pc;
  logic [31:0]        o_fetch_cnt;
  modport master (
    output o_imem_addr, o_imem_rd, o_valid, o_instr, o_opcode, o_pc, o_pc_plus2, o_fetch_cnt,
    input  i_imem_waitreq, i_imem_rddata, i_ready, i_redirect, i_redirect_pc
  );
  modport slave (
    input  o_imem_addr, o_imem_rd, o_valid, o_instr, o_opcode, o_pc, o_pc_plus2, o_fetch_cnt,
    output i_imem_waitreq, i_imem_rddata, i_ready, i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC/IR fetch stage with imem wait-states, decode handshake and PC redirect.
module instr_fetch #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {FETCH, RESP, HOLD} state_t;
  state_t             r_state;
  logic [PC_W-1:0]    r_fpc;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_plus2;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic [31:0]        r_cnt;
  logic [PC_W-1:0]    w_fpc_next;
  assign w_fpc_next       = r_fpc + PC_W'(2);
  assign bus.o_imem_addr  = r_fpc;
  assign bus.o_imem_rd    = (r_state == FETCH) && !reset;
  assign bus.o_valid      = r_valid;
  assign bus.o_instr      = r_instr;
  assign bus.o_opcode     = r_instr[4:0];
  assign bus.o_pc         = r_pc;
  assign bus.o_pc_plus2   = r_pc_plus2;
  assign bus.o_fetch_cnt  = r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_fpc      <= RESET_PC;
      r_pc       <= '0;
      r_pc_plus2 <= PC_W'(2);
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // delivery is counted even when a redirect squashes the stage in the same cycle
      if (r_state == HOLD && bus.i_ready && r_cnt != 32'hFFFF_FFFF)
        r_cnt <= r_cnt + 32'd1;
      if (bus.i_redirect) begin
        r_fpc   <= {bus.i_redirect_pc[PC_W-1:1], 1'b0};
        r_valid <= 1'b0;
        r_state <= FETCH;
      end else begin
        case (r_state)
          FETCH: r_state <= bus.i_imem_waitreq ? FETCH : RESP;
          RESP: begin
            r_instr    <= bus.i_imem_rddata;
            r_pc       <= r_fpc;
            r_pc_plus2 <= w_fpc_next;
            r_fpc      <= w_fpc_next;
            r_valid    <= 1'b1;
            r_state    <= HOLD;
          end
          HOLD: begin
            r_valid <= bus.i_ready ? 1'b0 : r_valid;
            r_state <= bus.i_ready ? FETCH : HOLD;
          end
          default: r_state <= FETCH;
        endcase
      end
    end
  end
endmodule
